// File: rtl/duck_hunt_pkg.sv
// Shared types for the zapper hit-test slice: FSM state encoding and target index helpers.
// No logic of its own; helpers are pure combinational functions.
// No flow control.
package duck_hunt_pkg;

    localparam int TGT_IDX_W   = 2;
    localparam int MAX_TARGETS = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FRAME,
        ST_BLACK,
        ST_TARGET,
        ST_RESULT,
        ST_REARM
    } shot_state_t;

    // Result of searching the live mask for the next target to show.
    typedef struct packed {
        logic                 found;
        logic [TGT_IDX_W-1:0] idx;
    } live_pick_t;

    // Lowest set bit of mask at or above position 'from'.
    function automatic live_pick_t next_live(input logic [MAX_TARGETS-1:0] mask,
                                             input logic [TGT_IDX_W:0]     from);
        live_pick_t pick;
        pick = '0;
        // Scan downward so the lowest qualifying index is the one kept.
        for (int i = MAX_TARGETS - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                pick.found = 1'b1;
                pick.idx   = TGT_IDX_W'(i);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/zapper_shot_sequencer_if.sv
// Bundle of zapper pins, VGA timing, renderer overrides and game-logic result signals.
// Wiring only, no latency.
// No flow control; result pulses are fire-and-forget.
interface zapper_shot_sequencer_if #(
    parameter int NUM_TARGETS = 2
);
    logic                                  trigger_in;
    logic                                  light_in;
    logic                                  frame_start;
    logic                                  visible_in;
    logic [NUM_TARGETS-1:0]                target_live;
    logic                                  force_black;
    logic                                  show_target;
    logic [duck_hunt_pkg::TGT_IDX_W-1:0]   target_sel;
    logic                                  busy;
    logic                                  hit;
    logic [duck_hunt_pkg::TGT_IDX_W-1:0]   hit_id;
    logic                                  miss;

    // Environment side: pins, video timing and game logic.
    modport master (
        output trigger_in, light_in, frame_start, visible_in, target_live,
        input  force_black, show_target, target_sel, busy, hit, hit_id, miss
    );

    // Sequencer side.
    modport slave (
        input  trigger_in, light_in, frame_start, visible_in, target_live,
        output force_black, show_target, target_sel, busy, hit, hit_id, miss
    );
endinterface

// File: rtl/zapper_input_cond.sv
// Synchronises zapper pins, debounces the trigger and detects a sustained light run per frame.
// Trigger: 2 sync + DEBOUNCE_CYCLES to accepted level, fire pulse the cycle after; light: 2 sync + run length.
// No flow control; fire is a single-cycle pulse the consumer must catch.
module zapper_input_cond #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LIGHT_MIN       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic trigger_raw,
    input  logic light_raw,
    input  logic frame_start,
    input  logic visible_in,
    output logic trig_level,
    output logic trig_fire,
    output logic seen
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LC_W = $clog2(LIGHT_MIN + 1);

    logic            trig_s1, trig_s2, trig_prev;
    logic            light_s1, light_s2;
    logic [DB_W-1:0] db_cnt;
    logic [LC_W-1:0] light_cnt;

    // Trigger sync and debounce. Reset assumes "pulled" so a trigger held
    // through reset must be released before it can ever fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_s1    <= 1'b0;
            trig_s2    <= 1'b0;
            trig_level <= 1'b0;
            trig_prev  <= 1'b0;
            db_cnt     <= '0;
        end else begin
            trig_s1   <= trigger_raw;
            trig_s2   <= trig_s1;
            trig_prev <= trig_level;
            if (trig_s2 == trig_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                trig_level <= trig_s2;
                db_cnt     <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Trigger is active-low: a shot fires on the accepted 1->0 edge.
    assign trig_fire = trig_prev & ~trig_level;

    // Light run counter; runs never span a frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            light_s1  <= 1'b1;
            light_s2  <= 1'b1;
            light_cnt <= '0;
            seen      <= 1'b0;
        end else begin
            light_s1 <= light_raw;
            light_s2 <= light_s1;
            if (frame_start) begin
                light_cnt <= '0;
                seen      <= 1'b0;
            end else if (light_s2) begin
                light_cnt <= '0;
            end else if (visible_in && (light_cnt != LC_W'(LIGHT_MIN))) begin
                light_cnt <= light_cnt + 1'b1;
                if (light_cnt == LC_W'(LIGHT_MIN - 1)) begin
                    seen <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/zapper_shot_sequencer.sv
// Runs a Duck Hunt hit test: one black frame, then one white-box frame per live target.
// Result pulses one cycle after the deciding frame_start; zero-mask shots miss one cycle after fire.
// No flow control; new trigger edges are ignored until the trigger is released after a shot.
module zapper_shot_sequencer
    import duck_hunt_pkg::*;
#(
    parameter int NUM_TARGETS     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LIGHT_MIN       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    zapper_shot_sequencer_if.slave   bus
);
    shot_state_t            state;
    logic [MAX_TARGETS-1:0] mask;
    logic [MAX_TARGETS-1:0] live_ext;
    logic                   trig_level, trig_fire, seen;
    live_pick_t             first_pick, next_pick;

    zapper_input_cond #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LIGHT_MIN       (LIGHT_MIN)
    ) u_cond (
        .clk         (clk),
        .rst         (rst),
        .trigger_raw (bus.trigger_in),
        .light_raw   (bus.light_in),
        .frame_start (bus.frame_start),
        .visible_in  (bus.visible_in),
        .trig_level  (trig_level),
        .trig_fire   (trig_fire),
        .seen        (seen)
    );

    assign live_ext   = MAX_TARGETS'(bus.target_live);
    assign first_pick = next_live(mask, '0);
    assign next_pick  = next_live(mask, {1'b0, bus.target_sel} + 3'd1);

    // Shot sequencing FSM; all renderer and result outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_REARM;
            mask            <= '0;
            bus.force_black <= 1'b0;
            bus.show_target <= 1'b0;
            bus.target_sel  <= '0;
            bus.busy        <= 1'b0;
            bus.hit         <= 1'b0;
            bus.hit_id      <= '0;
            bus.miss        <= 1'b0;
        end else begin
            bus.hit  <= 1'b0;
            bus.miss <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (trig_fire) begin
                        mask <= live_ext;
                        if (live_ext == '0) begin
                            bus.miss <= 1'b1;
                            state    <= ST_RESULT;
                        end else begin
                            bus.busy <= 1'b1;
                            state    <= ST_WAIT_FRAME;
                        end
                    end
                end
                ST_WAIT_FRAME: begin
                    if (bus.frame_start) begin
                        bus.force_black <= 1'b1;
                        state           <= ST_BLACK;
                    end
                end
                ST_BLACK: begin
                    if (bus.frame_start) begin
                        bus.force_black <= 1'b0;
                        // Light on an all-black screen means a lamp, not a target.
                        if (seen || !first_pick.found) begin
                            bus.miss <= 1'b1;
                            bus.busy <= 1'b0;
                            state    <= ST_RESULT;
                        end else begin
                            bus.show_target <= 1'b1;
                            bus.target_sel  <= first_pick.idx;
                            state           <= ST_TARGET;
                        end
                    end
                end
                ST_TARGET: begin
                    if (bus.frame_start) begin
                        if (seen) begin
                            bus.hit         <= 1'b1;
                            bus.hit_id      <= bus.target_sel;
                            bus.show_target <= 1'b0;
                            bus.target_sel  <= '0;
                            bus.busy        <= 1'b0;
                            state           <= ST_RESULT;
                        end else if (next_pick.found) begin
                            bus.target_sel <= next_pick.idx;
                        end else begin
                            bus.miss        <= 1'b1;
                            bus.show_target <= 1'b0;
                            bus.target_sel  <= '0;
                            bus.busy        <= 1'b0;
                            state           <= ST_RESULT;
                        end
                    end
                end
                ST_RESULT: begin
                    state <= ST_REARM;
                end
                ST_REARM: begin
                    if (trig_level) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_REARM;
                end
            endcase
        end
    end

endmodule
